// File: rtl/fluid_board_pio_input_capture.sv
// fluid_board_pio_input_capture
// Avalon-MM input PIO for the fluid board. Each external input bit is
// synchronised, then debounced. Selected rising/falling edges of the
// debounced value are latched into a write-1-to-clear capture register.
// A maskable interrupt is raised from that register.
module fluid_board_pio_input_capture #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Counter wide enough to reach DEBOUNCE_CYCLES-1. With 0 or 1 the
  // terminal count is 0, so the debounced value follows s after one stage.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'((DEBOUNCE_CYCLES > 1) ? (DEBOUNCE_CYCLES - 1) : 0);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
  localparam logic [2:0] ADDR_CAPTURE  = 3'd3;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd4;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd5;

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0]                  deb_q, deb_d;
  logic [WIDTH-1:0]                  deb_prev_q, deb_prev_d;
  logic [WIDTH-1:0]                  cap_q, cap_d;
  logic [WIDTH-1:0]                  irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0]                  rise_en_q, rise_en_d;
  logic [WIDTH-1:0]                  fall_en_q, fall_en_d;
  logic [31:0]                       readdata_q, readdata_d;

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] wr_bits;
  logic [31:0]      rd_val;
  logic             wr;
  logic             rd;
  logic             unused_writedata;

  assign wr      = chipselect & ~write_n;
  assign rd      = chipselect & ~read_n;
  assign wr_bits = writedata[WIDTH-1:0];
  assign s       = sync_q[SYNC_STAGES-1];

  // Bits of writedata above WIDTH have no register behind them.
  assign unused_writedata = ^writedata;

  // Shift each input through the synchroniser chain; stage 0 samples the pin.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in_port};
  end

  // Per-bit debounce: the counter runs while s disagrees with deb and deb
  // only follows s after DEBOUNCE_CYCLES consecutive disagreeing clocks.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = s[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  // Edge detection on the debounced value and capture with set-over-clear
  // priority so an edge landing on a clearing write is never lost.
  always_comb begin
    deb_prev_d = deb_q;
    rise       = deb_q & ~deb_prev_q;
    fall       = ~deb_q & deb_prev_q;
    clr        = (wr && (address == ADDR_CAPTURE)) ? wr_bits : '0;
    cap_d      = (cap_q & ~clr) | (rise & rise_en_q) | (fall & fall_en_q);
  end

  // Control register writes take effect at the strobe edge.
  always_comb begin
    irq_mask_d = irq_mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    if (wr) begin
      case (address)
        ADDR_IRQ_MASK: irq_mask_d = wr_bits;
        ADDR_RISE_EN:  rise_en_d  = wr_bits;
        ADDR_FALL_EN:  fall_en_d  = wr_bits;
        default:       ;
      endcase
    end
  end

  // Read mux; unused upper bits and reserved addresses return zero, and
  // readdata holds its value between reads.
  always_comb begin
    rd_val = '0;
    case (address)
      ADDR_DATA:     rd_val[WIDTH-1:0] = deb_q;
      ADDR_IRQ_MASK: rd_val[WIDTH-1:0] = irq_mask_q;
      ADDR_CAPTURE:  rd_val[WIDTH-1:0] = cap_q;
      ADDR_RISE_EN:  rd_val[WIDTH-1:0] = rise_en_q;
      ADDR_FALL_EN:  rd_val[WIDTH-1:0] = fall_en_q;
      default:       ;
    endcase
    readdata_d = rd ? rd_val : readdata_q;
  end

  // All state registers; reset clears everything so reset itself never
  // produces an edge (deb and deb_prev are both zero).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      cap_q      <= '0;
      irq_mask_q <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      readdata_q <= '0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      deb_q      <= deb_d;
      deb_prev_q <= deb_prev_d;
      cap_q      <= cap_d;
      irq_mask_q <= irq_mask_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & irq_mask_q);

endmodule

// File: tb/tb_fluid_board_pio_input_capture.sv
// Testbench for fluid_board_pio_input_capture (WIDTH=8, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4). A history-based reference model predicts readdata
// and irq every cycle; directed sequences add hand-computed checks.
module tb_fluid_board_pio_input_capture;

  localparam int WIDTH           = 8;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int HIST            = 4096;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic [2:0]  address    = 3'd0;
  logic        chipselect = 1'b0;
  logic        read_n     = 1'b1;
  logic        write_n    = 1'b1;
  logic [31:0] writedata  = 32'h0;
  logic [7:0]  in_port    = 8'h00;
  logic [31:0] readdata;
  logic        irq;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] rdv;

  fluid_board_pio_input_capture #(
    .WIDTH(WIDTH),
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .address(address),
    .chipselect(chipselect),
    .read_n(read_n),
    .write_n(write_n),
    .writedata(writedata),
    .in_port(in_port),
    .readdata(readdata),
    .irq(irq)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  // Reference model state: edge count since reset and per-edge histories.
  int          m_n;
  logic [7:0]  m_in_hist [HIST];
  logic [7:0]  m_s_hist  [HIST];
  logic [7:0]  m_deb, m_deb_prev, m_cap, m_mask, m_rise_en, m_fall_en;
  logic [31:0] m_readdata;
  logic [7:0]  m_nd, m_rise, m_fall, m_clr, m_ncap;
  logic        m_flip;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] value, input int cycles);
    in_port = value;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    read_n     = 1'b0;
    @(negedge clk);
    d          = readdata;
    chipselect = 1'b0;
    read_n     = 1'b1;
  endtask

  // Model: the debounced bit flips once s has disagreed with it on each of
  // the last DEBOUNCE_CYCLES edges, where s at edge n is the pin value seen
  // SYNC_STAGES edges earlier (zero before that much history exists).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_n        = 0;
      m_deb      = '0;
      m_deb_prev = '0;
      m_cap      = '0;
      m_mask     = '0;
      m_rise_en  = '0;
      m_fall_en  = '0;
      m_readdata = '0;
    end else if (m_n < HIST - 1) begin
      m_n = m_n + 1;
      m_in_hist[m_n] = in_port;
      m_s_hist[m_n]  = (m_n > SYNC_STAGES) ? m_in_hist[m_n - SYNC_STAGES] : 8'h00;
      m_nd = m_deb;
      for (int b = 0; b < WIDTH; b++) begin
        m_flip = (m_n >= DEBOUNCE_CYCLES);
        for (int j = 0; j < DEBOUNCE_CYCLES; j++) begin
          if (m_flip && (m_s_hist[m_n - j][b] == m_deb[b])) m_flip = 1'b0;
        end
        if (m_flip) m_nd[b] = ~m_deb[b];
      end
      m_rise = m_deb & ~m_deb_prev;
      m_fall = ~m_deb & m_deb_prev;
      m_clr  = (chipselect && !write_n && address == 3'd3) ? writedata[7:0] : 8'h00;
      m_ncap = (m_cap & ~m_clr) | (m_rise & m_rise_en) | (m_fall & m_fall_en);
      if (chipselect && !read_n) begin
        case (address)
          3'd0:    m_readdata = {24'h0, m_deb};
          3'd2:    m_readdata = {24'h0, m_mask};
          3'd3:    m_readdata = {24'h0, m_cap};
          3'd4:    m_readdata = {24'h0, m_rise_en};
          3'd5:    m_readdata = {24'h0, m_fall_en};
          default: m_readdata = 32'h0;
        endcase
      end
      if (chipselect && !write_n) begin
        case (address)
          3'd2:    m_mask    = writedata[7:0];
          3'd4:    m_rise_en = writedata[7:0];
          3'd5:    m_fall_en = writedata[7:0];
          default: ;
        endcase
      end
      m_deb_prev = m_deb;
      m_deb      = m_nd;
      m_cap      = m_ncap;
    end
  end

  // Every falling edge: DUT outputs must match the model.
  always @(negedge clk) begin
    checkOutput("cycle_readdata", readdata, m_readdata);
    checkOutput("cycle_irq", 32'(irq), 32'(|(m_cap & m_mask)));
  end

  // Directed sequences with hand-computed expectations.
  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_readdata", readdata, 32'h0);
    checkOutput("reset_irq", 32'(irq), 32'h0);
    reset_n = 1'b1;

    // DATA read after the inputs have settled.
    applyStimulus(8'hA5, 20);
    bus_read(3'd0, rdv);
    checkOutput("t1_data", rdv, 32'h0000_00A5);
    checkOutput("t1_model_deb", {24'h0, m_deb}, 32'h0000_00A5);
    bus_read(3'd1, rdv);
    checkOutput("t1_reserved1", rdv, 32'h0);

    // Rising edge on bit0 with interrupt; exact latency and clear.
    applyStimulus(8'h00, 20);
    bus_write(3'd3, 32'hFF);
    bus_write(3'd4, 32'h01);
    bus_write(3'd2, 32'h01);
    bus_write(3'd0, 32'hFF);
    bus_write(3'd7, 32'hFF);
    bus_read(3'd0, rdv);
    checkOutput("t2_data_ro", rdv, 32'h0);
    bus_read(3'd7, rdv);
    checkOutput("t2_reserved7", rdv, 32'h0);
    in_port = 8'h01;
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      checkOutput($sformatf("t2_irq_edge%0d", e), 32'(irq), 32'(e == 7));
    end
    bus_read(3'd3, rdv);
    checkOutput("t2_cap_set", rdv, 32'h01);
    bus_write(3'd3, 32'h01);
    checkOutput("t2_irq_cleared", 32'(irq), 32'h0);
    bus_read(3'd3, rdv);
    checkOutput("t2_cap_cleared", rdv, 32'h0);

    // Glitch filter: 3-clock pulse discarded, 4-clock pulse passes.
    applyStimulus(8'h00, 12);
    bus_write(3'd4, 32'hFF);
    bus_write(3'd5, 32'hFF);
    bus_write(3'd3, 32'hFF);
    applyStimulus(8'h02, 3);
    applyStimulus(8'h00, 12);
    bus_read(3'd0, rdv);
    checkOutput("t3_glitch_data", rdv, 32'h0);
    bus_read(3'd3, rdv);
    checkOutput("t3_glitch_cap", rdv, 32'h0);
    applyStimulus(8'h02, 4);
    applyStimulus(8'h00, 3);
    bus_read(3'd3, rdv);
    checkOutput("t3_rise_cap", rdv, 32'h02);
    bus_write(3'd3, 32'h02);
    bus_read(3'd3, rdv);
    checkOutput("t3_before_fall", rdv, 32'h0);
    repeat (2) @(negedge clk);
    bus_read(3'd3, rdv);
    checkOutput("t3_fall_cap", rdv, 32'h02);

    // Upper bits of a control register ignore writes and read zero.
    bus_write(3'd2, 32'hFFFF_FF5A);
    bus_read(3'd2, rdv);
    checkOutput("t3_mask_width", rdv, 32'h0000_005A);

    // Falling-edge capture on bit7 with the interrupt masked, then unmasked.
    bus_write(3'd4, 32'h0);
    bus_write(3'd5, 32'h0);
    bus_write(3'd2, 32'h0);
    applyStimulus(8'h80, 12);
    bus_write(3'd3, 32'hFF);
    bus_write(3'd5, 32'h80);
    applyStimulus(8'h00, 12);
    bus_read(3'd3, rdv);
    checkOutput("t4_cap_fall", rdv, 32'h80);
    checkOutput("t4_irq_masked", 32'(irq), 32'h0);
    bus_write(3'd2, 32'h80);
    checkOutput("t4_irq_unmasked", 32'(irq), 32'h1);

    // Rise on bit2 lands on the same edge as a clearing write: set wins.
    bus_write(3'd4, 32'h04);
    in_port = 8'h04;
    repeat (6) @(negedge clk);
    bus_write(3'd3, 32'h04);
    bus_read(3'd3, rdv);
    checkOutput("t5_collision", rdv, 32'h84);

    // Asynchronous reset in the middle of a debounce on bit3.
    applyStimulus(8'h08, 4);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("t6_reset_readdata", readdata, 32'h0);
    checkOutput("t6_reset_irq", 32'(irq), 32'h0);
    checkOutput("t6_model_cap", {24'h0, m_cap}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    bus_write(3'd4, 32'h08);
    bus_write(3'd2, 32'h08);
    for (int e = 3; e <= 7; e++) begin
      @(negedge clk);
      checkOutput($sformatf("t6_irq_edge%0d", e), 32'(irq), 32'(e == 7));
    end
    bus_read(3'd3, rdv);
    checkOutput("t6_cap", rdv, 32'h08);
    bus_read(3'd0, rdv);
    checkOutput("t6_data", rdv, 32'h08);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #100000;
    miscompares++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
